// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: sequences the program counter, issues one imem read per fetch,
// waits the memory latency and strobes the captured instruction to the IR.
module inst_fetch_unit #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MEM_LAT  = 1,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              ir_ready,
   input  logic [DATA_W-1:0] imem_data,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd_en,
   output logic [DATA_W-1:0] inst_out,
   output logic              inst_en,
   output logic [ADDR_W-1:0] pc,
   output logic              busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DELIVER,
      S_STALL
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_addr;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_inst;
   logic                r_rd_en;
   logic                r_inst_en;
   logic                r_busy;

   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic [ADDR_W-1:0]   w_pc_inc;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [DATA_W-1:0]   w_inst_nxt;

   // Next-state, pc, latency counter and capture; halt/jump override normal sequencing
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      w_inst_nxt  = r_inst;
      w_pc_inc    = r_pc + ADDR_W'(1);

      case (r_state)
         S_IDLE: begin
            if (jump_en) begin
               w_pc_nxt = jump_addr;
            end else if (start && !halt) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_cnt_nxt   = CNT_W'(MEM_LAT - 1);
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_inst_nxt  = imem_data;
               w_state_nxt = S_DELIVER;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_DELIVER: begin
            if (ir_ready) begin
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_STALL;
            end
         end
         S_STALL: begin
            if (ir_ready) begin
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // An in-flight fetch is dropped; inst_out keeps the last delivered instruction
      if (r_state != S_IDLE) begin
         if (jump_en) begin
            w_pc_nxt    = jump_addr;
            w_state_nxt = S_FETCH;
            w_inst_nxt  = r_inst;
         end
         if (halt) begin
            w_state_nxt = S_IDLE;
            w_inst_nxt  = r_inst;
            w_cnt_nxt   = '0;
            if (!jump_en) begin
               w_pc_nxt = r_pc;
            end
         end
      end
   end

   // State and registered outputs, all derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_pc      <= ADDR_W'(RESET_PC);
         r_addr    <= ADDR_W'(RESET_PC);
         r_cnt     <= '0;
         r_inst    <= '0;
         r_rd_en   <= 1'b0;
         r_inst_en <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_addr    <= w_pc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_inst    <= w_inst_nxt;
         r_rd_en   <= (w_state_nxt == S_FETCH);
         r_inst_en <= (w_state_nxt == S_DELIVER);
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign imem_addr  = r_addr;
   assign imem_rd_en = r_rd_en;
   assign inst_out   = r_inst;
   assign inst_en    = r_inst_en;
   assign pc         = r_pc;
   assign busy       = r_busy;

endmodule
